// File: rtl/key_pkg.sv
// key_pkg: key index constants, auto-repeat state type and a small helper shared by the key path
package key_pkg;
  localparam int KEY_START = 0;
  localparam int KEY_STOP  = 1;
  localparam int KEY_NEXT  = 2;
  localparam int KEY_PRE   = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2} rep_state_e;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/key_pulse_gen_if.sv
// key_pulse_gen_if: raw active-low keys in, command pulses and debounced key levels out
interface key_pulse_gen_if;
  logic [3:0] key_n;
  logic       start;
  logic       stop;
  logic       next_song;
  logic       pre_song;
  logic [3:0] key_level;
  modport master (output key_n, input start, stop, next_song, pre_song, key_level);
  modport slave  (input key_n, output start, stop, next_song, pre_song, key_level);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer, restart-on-bounce debounce counter, stable level and press-edge flag
module key_debounce #(
  parameter int DB_CNT = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);
  localparam int W = $clog2(DB_CNT) + 1;
  logic         r_s1;
  logic         r_s2;
  logic         r_stable;
  logic         r_press;
  logic [W-1:0] r_cnt;
  logic         w_diff;
  logic         w_done;
  assign w_diff  = (~r_s2) ^ r_stable;
  assign w_done  = w_diff && (r_cnt == W'(DB_CNT - 1));
  assign o_level = r_stable;
  assign o_press = r_press;
  // synchronize the raw key, count while it disagrees with the stable level, toggle after DB_CNT cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1     <= i_key_n;
      r_s2     <= r_s1;
      r_cnt    <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
      r_stable <= r_stable ^ w_done;
      r_press  <= w_done & ~r_stable;
    end
endmodule

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: debounced key commands with stop>start>next>pre arbitration; KEY_AUTOREPEAT_EN adds next/pre auto-repeat
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int CLK_FRE         = 50_000_000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 200
) (
  input  logic clk,
  input  logic rst_n,
  key_pulse_gen_if.slave kp
);
  localparam int DB_CNT = CLK_FRE / 1000 * DEBOUNCE_MS;
  logic [3:0] w_level;
  logic [3:0] w_press;
  logic [3:0] w_req;
  logic       r_start;
  logic       r_stop;
  logic       r_next;
  logic       r_pre;
  genvar i;
  for (i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DB_CNT(DB_CNT)) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_key_n (kp.key_n[i]),
      .o_level (w_level[i]),
      .o_press (w_press[i])
    );
  end
`ifdef KEY_AUTOREPEAT_EN
  localparam int RD_CNT = CLK_FRE / 1000 * REPEAT_DELAY_MS;
  localparam int RR_CNT = CLK_FRE / 1000 * REPEAT_RATE_MS;
  localparam int RW     = $clog2(max2(RD_CNT, RR_CNT)) + 1;
  logic [1:0] w_rep;
  for (i = 0; i < 2; i++) begin : g_rep
    localparam int K = KEY_NEXT + i;
    rep_state_e    r_state;
    logic [RW-1:0] r_cnt;
    logic          w_hit;
    assign w_hit    = (r_state == HOLD && r_cnt == RW'(RD_CNT - 1)) ||
                      (r_state == REPEAT && r_cnt == RW'(RR_CNT - 1));
    assign w_rep[i] = w_hit & w_level[K];
    // press arms HOLD, initial delay enters REPEAT, each terminal count requests a pulse, release returns to IDLE
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (!w_level[K]) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (r_state == IDLE) begin
        r_state <= w_press[K] ? HOLD : IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_hit ? REPEAT : r_state;
        r_cnt   <= w_hit ? '0 : r_cnt + 1'b1;
      end
  end
  assign w_req = {w_press[KEY_PRE:KEY_NEXT] | w_rep, w_press[KEY_STOP:KEY_START]};
`else
  assign w_req = w_press;
`endif
  // register one winning request per cycle; losers are dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_next  <= 1'b0;
      r_pre   <= 1'b0;
    end else begin
      r_stop  <= w_req[KEY_STOP];
      r_start <= w_req[KEY_START] & ~w_req[KEY_STOP];
      r_next  <= w_req[KEY_NEXT] & ~|w_req[KEY_STOP:KEY_START];
      r_pre   <= w_req[KEY_PRE] & ~|w_req[KEY_NEXT:KEY_START];
    end
  assign kp.start     = r_start;
  assign kp.stop      = r_stop;
  assign kp.next_song = r_next;
  assign kp.pre_song  = r_pre;
  assign kp.key_level = w_level;
endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: directed checks of debounce latency, glitch rejection, priority, auto-repeat and async reset
module tb_key_pulse_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int n_st = 0, n_sp = 0, n_nx = 0, n_pr = 0;
  int b_st = 0, b_sp = 0, b_nx = 0, b_pr = 0;
  key_pulse_gen_if kp ();
  key_pulse_gen #(.CLK_FRE(1000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );
  always #5 clk = ~clk;
  // count high cycles of each command output
  always @(negedge clk)
    if (rst_n) begin
      n_st += int'(kp.start);
      n_sp += int'(kp.stop);
      n_nx += int'(kp.next_song);
      n_pr += int'(kp.pre_song);
    end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic snap();
    b_st = n_st;
    b_sp = n_sp;
    b_nx = n_nx;
    b_pr = n_pr;
  endtask
  initial begin
    kp.key_n = 4'hF;
    tick(3);
    check("rst_start", int'(kp.start), 0);
    check("rst_stop", int'(kp.stop), 0);
    check("rst_next", int'(kp.next_song), 0);
    check("rst_pre", int'(kp.pre_song), 0);
    check("rst_level", int'(kp.key_level), 0);
    rst_n = 1'b1;
    tick(5);
    snap();
    kp.key_n = 4'b1011;
    tick(21);
    check("next_lvl_p21", int'(kp.key_level[2]), 0);
    tick(1);
    check("next_lvl_p22", int'(kp.key_level[2]), 1);
    check("next_pulse_p22", int'(kp.next_song), 0);
    tick(1);
    check("next_pulse_p23", int'(kp.next_song), 1);
    tick(1);
    check("next_pulse_p24", int'(kp.next_song), 0);
    tick(76);
    kp.key_n = 4'hF;
    tick(21);
    check("next_rel_r21", int'(kp.key_level[2]), 1);
    tick(1);
    check("next_rel_r22", int'(kp.key_level[2]), 0);
    tick(30);
    check("next_count", n_nx - b_nx, 1);
    check("next_other_st", n_st - b_st, 0);
    check("next_other_sp", n_sp - b_sp, 0);
    check("next_other_pr", n_pr - b_pr, 0);
    snap();
    for (int i = 0; i < 12; i++) begin
      kp.key_n[0] = i[0];
      tick(5);
    end
    kp.key_n = 4'hF;
    tick(40);
    check("bounce_level", int'(kp.key_level[0]), 0);
    check("bounce_start", n_st - b_st, 0);
    snap();
    kp.key_n = 4'b1100;
    tick(22);
    check("prio_stop_p22", int'(kp.stop), 0);
    tick(1);
    check("prio_stop_p23", int'(kp.stop), 1);
    check("prio_start_p23", int'(kp.start), 0);
    tick(1);
    check("prio_stop_p24", int'(kp.stop), 0);
    kp.key_n = 4'hF;
    tick(60);
    check("prio_stop_cnt", n_sp - b_sp, 1);
    check("prio_start_cnt", n_st - b_st, 0);
    snap();
    kp.key_n = 4'b0111;
    tick(22);
    check("pre_p22", int'(kp.pre_song), 0);
    tick(1);
    check("pre_p23", int'(kp.pre_song), 1);
    tick(1);
    check("pre_p24", int'(kp.pre_song), 0);
`ifdef KEY_AUTOREPEAT_EN
    tick(498);
    check("rep_p522", int'(kp.pre_song), 0);
    tick(1);
    check("rep_p523", int'(kp.pre_song), 1);
    tick(200);
    check("rep_p723", int'(kp.pre_song), 1);
    tick(200);
    check("rep_p923", int'(kp.pre_song), 1);
    tick(77);
`else
    tick(976);
`endif
    kp.key_n = 4'hF;
    tick(200);
`ifdef KEY_AUTOREPEAT_EN
    check("pre_count", n_pr - b_pr, 4);
`else
    check("pre_count", n_pr - b_pr, 1);
`endif
    check("pre_other_nx", n_nx - b_nx, 0);
    kp.key_n = 4'b1101;
    tick(23);
    check("rst_pre_stop", int'(kp.stop), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_stop", int'(kp.stop), 0);
    check("async_level", int'(kp.key_level), 0);
    tick(3);
    rst_n = 1'b1;
    tick(22);
    check("held_stop_r22", int'(kp.stop), 0);
    check("held_lvl_r22", int'(kp.key_level[1]), 1);
    tick(1);
    check("held_stop_r23", int'(kp.stop), 1);
    tick(1);
    check("held_stop_r24", int'(kp.stop), 0);
    kp.key_n = 4'hF;
    tick(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
